// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data access) arbiter onto a single memory port.
// Data wins contention unless the fetch port has been starved STARVE_LIMIT times.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [WW-1:0]     wait_q, wait_d;

    logic grant_i, grant_d, timed_out;

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        starve_d  = starve_q;
        wait_d    = wait_q;

        // Fetch wins contention only once the starvation counter has saturated.
        grant_i   = i_req && (!d_req || (starve_q == SW'(STARVE_LIMIT)));
        grant_d   = d_req && !grant_i;
        timed_out = (wait_q == WW'(TIMEOUT - 1));

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d   = BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_be_d    = 4'hF;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    starve_d  = '0;
                    wait_d    = '0;
                end else if (grant_d) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_be_d    = d_be;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    wait_d    = '0;
                    if (i_req && (starve_q != SW'(STARVE_LIMIT)))
                        starve_d = starve_q + 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready || timed_out) begin
                    state_d = ACK;
                    m_req_d = 1'b0;
                    err_d   = !m_ready;
                    if (state_q == BUSY_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_ready ? m_rdata : '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_ready ? m_rdata : '0;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            starve_q  <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            starve_q  <= starve_d;
            wait_q    <= wait_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, write, contention order, timeout,
// stray m_ready and mid-transaction reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we, m_ready;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [3:0]  d_be;
    logic        i_ack, d_ack, m_req, m_we, err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [3:0]  m_be;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] exp_addr;
    int          mcount;
    int          waited;
    logic        is_i;

    initial begin
        rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; m_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; d_be = '0;
        @(negedge clk);
        step(); step();
        check("rst_m_req", {31'b0, m_req}, 32'd0);
        check("rst_acks_err", {29'b0, i_ack, d_ack, err}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        rst_n = 1'b1;
        step();

        // Single fetch
        i_req = 1; i_addr = 32'h100;
        step();
        check("fetch_m_req", {31'b0, m_req}, 32'd1);
        check("fetch_m_addr", m_addr, 32'h100);
        check("fetch_m_we_be", {27'b0, m_we, m_be}, 32'h0F);
        m_ready = 1; m_rdata = 32'h8C220004;
        step();
        m_ready = 0; i_req = 0;
        check("fetch_ack", {30'b0, i_ack, d_ack}, 32'd2);
        check("fetch_rdata", i_rdata, 32'h8C220004);
        check("fetch_m_req_low", {31'b0, m_req}, 32'd0);
        step();
        check("fetch_ack_pulse", {31'b0, i_ack}, 32'd0);

        // Data write
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'h1234;
        step();
        check("wr_m_addr", m_addr, 32'h40);
        check("wr_m_wdata", m_wdata, 32'h1234);
        check("wr_m_we_be", {27'b0, m_we, m_be}, 32'h13);
        m_ready = 1; m_rdata = 32'hAAAA5555;
        step();
        m_ready = 0; d_req = 0; d_we = 0;
        check("wr_ack", {30'b0, i_ack, d_ack}, 32'd1);
        check("wr_d_rdata", d_rdata, 32'hAAAA5555);
        step();
        check("wr_ack_pulse", {31'b0, d_ack}, 32'd0);

        // Contention: expected grant order D,D,D,D,I,D,D,D,D,I
        i_req = 1; i_addr = 32'h200; d_req = 1; d_addr = 32'h300; d_be = 4'hF;
        for (int k = 0; k < 10; k++) begin
            is_i = (k == 4) || (k == 9);
            exp_addr = is_i ? 32'h200 : 32'h300;
            waited = 0;
            while (!m_req && waited < 8) begin
                step();
                waited++;
            end
            check($sformatf("cont_grant%0d", k), m_addr, exp_addr);
            m_ready = 1; m_rdata = 32'hC0DE0000 + k;
            step();
            m_ready = 0;
            check($sformatf("cont_ack%0d", k), {30'b0, i_ack, d_ack}, is_i ? 32'd2 : 32'd1);
            if (k == 9) begin
                i_req = 0; d_req = 0;
            end
        end
        step();
        check("cont_i_rdata", i_rdata, 32'hC0DE0009);
        check("cont_d_rdata", d_rdata, 32'hC0DE0008);

        // Timeout on a data read
        d_req = 1; d_we = 0; d_addr = 32'h50;
        mcount = 0;
        step();
        waited = 0;
        while (!d_ack && waited < 40) begin
            mcount += int'(m_req);
            step();
            waited++;
        end
        check("to_m_req_cycles", mcount, 32'd16);
        check("to_ack_err", {29'b0, i_ack, d_ack, err}, 32'd3);
        check("to_d_rdata", d_rdata, 32'd0);
        d_req = 0;
        step();
        check("to_err_pulse", {31'b0, err}, 32'd0);

        // Stray m_ready while idle
        m_ready = 1; m_rdata = 32'hDEADBEEF;
        step(); step();
        m_ready = 0;
        check("stray_no_ack", {29'b0, i_ack, d_ack, m_req}, 32'd0);
        check("stray_i_rdata", i_rdata, 32'hC0DE0009);
        check("stray_d_rdata", d_rdata, 32'd0);

        // Reset during BUSY_I
        i_req = 1; i_addr = 32'h400;
        step();
        check("rmid_busy", {31'b0, m_req}, 32'd1);
        rst_n = 0;
        step();
        check("rmid_m_req", {31'b0, m_req}, 32'd0);
        check("rmid_no_ack", {30'b0, i_ack, d_ack}, 32'd0);
        rst_n = 1;
        step();
        check("rmid_regrant", {31'b0, m_req}, 32'd1);
        check("rmid_addr", m_addr, 32'h400);
        m_ready = 1; m_rdata = 32'h77;
        step();
        m_ready = 0; i_req = 0;
        check("rmid_ack", {30'b0, i_ack, d_ack}, 32'd2);
        check("rmid_rdata", i_rdata, 32'h77);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width in bits.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, number of cycles the instruction port may lose arbitration before it is forced to win.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, maximum number of cycles to wait for m_ready.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
 clk  in  1  sole clock, rising edge.
 rst_n  in  1  reset, synchronous, active-low.
 i_req  in  1  instruction-fetch request.
 i_addr  in  ADDR_W  fetch address.
 i_ack  out  1  one-cycle pulse, fetch complete.
 i_rdata  out  DATA_W  fetch data, valid with i_ack.
 d_req  in  1  data-access request.
 d_we  in  1  1 = write, 0 = read.
 d_be  in  4  byte enables.
 d_addr  in  ADDR_W  data address.
 d_wdata  in  DATA_W  write data.
 d_ack  out  1  one-cycle pulse, data access complete.
 d_rdata  out  DATA_W  read data, valid with d_ack.
 m_req  out  1  memory request, held until completion.
 m_we  out  1  memory write enable.
 m_be  out  4  memory byte enables.
 m_addr  out  ADDR_W  memory address.
 m_wdata  out  DATA_W  memory write data.
 m_rdata  in  DATA_W  memory read data, valid with m_ready.
 m_ready  in  1  memory completion, single-cycle.
 err  out  1  one-cycle pulse on timeout, coincident with the failing ack.

Function
REQ-006 The block SHALL implement the states IDLE, BUSY_I, BUSY_D and ACK.
REQ-007 In IDLE with only i_req set, the block SHALL go to BUSY_I; with only d_req set, it SHALL go to BUSY_D.
REQ-008 In IDLE with both requests set, the block SHALL grant D, except when starve_cnt == STARVE_LIMIT, in which case it SHALL grant I.
REQ-009 On the grant edge, the block SHALL register m_addr/m_we/m_be/m_wdata from the winning port; for I, m_we=0 and m_be=4'hF.
REQ-010 The block SHALL assert m_req in the cycle after the grant decision and hold all m_* outputs stable until m_ready or timeout.
REQ-011 Requesters SHALL hold req and their request fields stable until ack; a req deassertion mid-transaction SHALL NOT abort the memory access.
REQ-012 When m_ready is sampled high in BUSY_x, the block SHALL deassert m_req, capture m_rdata into x_rdata and go to ACK.
REQ-013 In ACK, the block SHALL assert x_ack for exactly one cycle and then return to IDLE.
REQ-014 The minimum latency from req to ack SHALL be 3 cycles (grant, m_req with m_ready=1, ack); with no contention, back-to-back grants SHALL be at most one per 3 cycles.
REQ-015 x_rdata SHALL hold its last captured value until the next completion for that port; d_rdata SHALL update on writes too, taking m_rdata as-is.
REQ-016 starve_cnt SHALL be a saturating counter (0..STARVE_LIMIT) that increments in IDLE when i_req && d_req and D wins, clears when I is granted, and holds otherwise.
REQ-017 wait_cnt SHALL clear on entry to BUSY_x and increment each BUSY cycle without m_ready.
REQ-018 When wait_cnt reaches TIMEOUT-1 without m_ready, the block SHALL deassert m_req, set x_rdata = 0, go to ACK, and pulse err together with x_ack.
REQ-019 An m_ready outside BUSY states SHALL be ignored.
REQ-020 i_ack and d_ack SHALL never be asserted in the same cycle.

Reset
REQ-021 While rst_n is low at a clk edge, the block SHALL set the state to IDLE, set m_req, i_ack, d_ack and err to 0, set m_addr, m_wdata, m_we, m_be, i_rdata and d_rdata to 0, and set starve_cnt and wait_cnt to 0.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction with no ack, and m_req SHALL be low in the cycle after the reset edge.

Verification
REQ-023 Single fetch: i_req=1, i_addr=0x100, and m_ready=1 in the first m_req cycle with m_rdata=0x8C220004 -> m_addr=0x100, m_we=0, and i_ack pulses 3 cycles after req with i_rdata=0x8C220004.
REQ-024 Data write: d_we=1, d_be=4'b0011, d_addr=0x40, d_wdata=0x1234 -> the m_* outputs match these values, d_ack pulses once, and i_ack stays 0.
REQ-025 Contention: i_req and d_req held continuously and m_ready immediate -> grant order D,D,D,D,I,D,D,D,D,I with STARVE_LIMIT=4.
REQ-026 Timeout: d_req with m_ready held 0 -> m_req is high for exactly 16 cycles, then d_ack and err pulse together with d_rdata=0.
REQ-027 Reset mid-transaction: rst_n low during BUSY_I -> next cycle m_req=0, no i_ack, and the state is IDLE; a new request after release completes normally.
REQ-028 Stray m_ready while IDLE -> no ack, no state change, and x_rdata unchanged.
